op_queue_arbiter: RTL and testbench

Shares one `v2_OpCentricQueue` instance between `p_nreqs` clients. Each client issues one of the four queue operations (enq_back, enq_front, deq_front, deq_back) through a valid/ready request port. The block grants clients round-robin, drives exactly one queue `*_req` line at a time, waits for the matching `*_cpl`, and returns a tagged response. It sits between client logic and the queue's four op ports, which it drives directly.

---
 rtl/op_queue_pkg.sv | 30 +++
 rtl/op_queue_rr_arb.sv | 30 +++
 rtl/op_queue_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_op_queue_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_queue_pkg.sv
// Shared types for the op-queue arbiter: opcodes, FSM states, opcode helper.
// Default macros TOP_DEPTH / TOP_CHANWIDTH are supplied here when the build does not set them.
`ifndef TOP_DEPTH
`define TOP_DEPTH 8
`endif
`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 32
`endif

package op_queue_pkg;

  typedef enum logic [1:0] {
    OP_ENQ_BACK  = 2'd0,
    OP_ENQ_FRONT = 2'd1,
    OP_DEQ_FRONT = 2'd2,
    OP_DEQ_BACK  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Enqueue opcodes have the upper bit clear.
  function automatic logic op_is_enq(input op_e op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/op_queue_rr_arb.sv
// Combinational round-robin grant: first request at or after ptr wins.
module op_queue_rr_arb #(
  parameter int unsigned p_nreqs = 4,
  localparam int unsigned IdxW = $clog2(p_nreqs)
) (
  input  logic [p_nreqs-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [p_nreqs-1:0] gnt,
  output logic [IdxW-1:0]    idx,
  output logic               any
);

  // Scan from ptr upward; power-of-two width makes the index wrap for free.
  always_comb begin
    logic [IdxW-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < p_nreqs; i++) begin
      cand = IdxW'(ptr + IdxW'(i));
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/op_queue_arbiter.sv
// Round-robin arbiter sharing one op-centric queue between p_nreqs clients.
// Optional occupancy tracking / refusal is enabled by defining OPQ_ARB_OCC_EN.
`ifndef TOP_DEPTH
`define TOP_DEPTH 8
`endif
`ifndef TOP_CHANWIDTH
`define TOP_CHANWIDTH 32
`endif

module op_queue_arbiter
  import op_queue_pkg::*;
#(
  parameter int unsigned p_nreqs    = 4,
  parameter int unsigned p_depth    = `TOP_DEPTH,
  parameter int unsigned p_bitwidth = `TOP_CHANWIDTH,
  localparam int unsigned IdW = $clog2(p_nreqs)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [p_nreqs-1:0]                  cli_val,
  output logic [p_nreqs-1:0]                  cli_rdy,
  input  logic [p_nreqs-1:0][1:0]             cli_op,
  input  logic [p_nreqs-1:0][p_bitwidth-1:0]  cli_data,
  output logic                                rsp_val,
  output logic [IdW-1:0]                      rsp_id,
  output logic [p_bitwidth-1:0]               rsp_data,
  output logic                                rsp_err,
  output logic                                enq_back_req,
  output logic                                enq_front_req,
  output logic                                deq_front_req,
  output logic                                deq_back_req,
  input  logic                                enq_back_cpl,
  input  logic                                enq_front_cpl,
  input  logic                                deq_front_cpl,
  input  logic                                deq_back_cpl,
  output logic [p_bitwidth-1:0]               enq_back_data,
  output logic [p_bitwidth-1:0]               enq_front_data,
  input  logic [p_bitwidth-1:0]               deq_front_data,
  input  logic [p_bitwidth-1:0]               deq_back_data
);

  state_e                state_q, state_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  op_e                   op_q, op_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [3:0]            req_q, req_d;
  logic [p_bitwidth-1:0] wdata_q, wdata_d;
  logic                  rsp_val_q, rsp_val_d;
  logic [IdW-1:0]        rsp_id_q, rsp_id_d;
  logic [p_bitwidth-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [p_nreqs-1:0]    gnt;
  logic [IdW-1:0]        win_idx;
  logic                  win_any;
  op_e                   win_op;
  logic                  accept_c;
  logic                  refuse_c;
  logic                  cpl_hit_c;
  logic [3:0]            cpl_vec;
  logic [p_bitwidth-1:0] deq_data_c;

  op_queue_rr_arb #(.p_nreqs(p_nreqs)) u_rr_arb (
    .req (cli_val),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign win_op     = op_e'(cli_op[win_idx]);
  assign accept_c   = (state_q == ST_IDLE) && win_any;
  assign cli_rdy    = (state_q == ST_IDLE) ? gnt : '0;
  assign cpl_vec    = {deq_back_cpl, deq_front_cpl, enq_front_cpl, enq_back_cpl};
  assign cpl_hit_c  = (state_q == ST_ISSUE) && cpl_vec[op_q];
  assign deq_data_c = (op_q == OP_DEQ_BACK) ? deq_back_data : deq_front_data;

`ifdef OPQ_ARB_OCC_EN
  localparam int unsigned OccW = $clog2(p_depth + 1);
  logic [OccW-1:0] occ_q, occ_d;

  // Track queue fill level from completions only.
  always_comb begin
    occ_d = occ_q;
    if (cpl_hit_c) occ_d = op_is_enq(op_q) ? OccW'(occ_q + OccW'(1)) : OccW'(occ_q - OccW'(1));
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign refuse_c = op_is_enq(win_op) ? (occ_q == OccW'(p_depth)) : (occ_q == '0);
`else
  logic unused_depth;
  assign unused_depth = ^32'(p_depth);
  assign refuse_c     = 1'b0;
`endif

  // Next-state and datapath: accept, issue one req, wait for its cpl, respond.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_d       = op_q;
    id_d       = id_q;
    req_d      = req_q;
    wdata_d    = wdata_q;
    rsp_val_d  = 1'b0;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          rr_ptr_d = IdW'(win_idx + IdW'(1));
          op_d     = win_op;
          id_d     = win_idx;
          if (refuse_c) begin
            state_d    = ST_RESP;
            rsp_val_d  = 1'b1;
            rsp_id_d   = win_idx;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            state_d        = ST_ISSUE;
            req_d          = '0;
            req_d[win_op]  = 1'b1;
            wdata_d        = op_is_enq(win_op) ? cli_data[win_idx] : '0;
          end
        end
      end
      ST_ISSUE: begin
        if (cpl_hit_c) begin
          state_d    = ST_RESP;
          req_d      = '0;
          wdata_d    = '0;
          rsp_val_d  = 1'b1;
          rsp_id_d   = id_q;
          rsp_err_d  = 1'b0;
          rsp_data_d = op_is_enq(op_q) ? '0 : deq_data_c;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      op_q       <= OP_ENQ_BACK;
      id_q       <= '0;
      req_q      <= '0;
      wdata_q    <= '0;
      rsp_val_q  <= 1'b0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_q       <= op_d;
      id_q       <= id_d;
      req_q      <= req_d;
      wdata_q    <= wdata_d;
      rsp_val_q  <= rsp_val_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign enq_back_req   = req_q[OP_ENQ_BACK];
  assign enq_front_req  = req_q[OP_ENQ_FRONT];
  assign deq_front_req  = req_q[OP_DEQ_FRONT];
  assign deq_back_req   = req_q[OP_DEQ_BACK];
  assign enq_back_data  = wdata_q;
  assign enq_front_data = wdata_q;
  assign rsp_val        = rsp_val_q;
  assign rsp_id         = rsp_id_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_op_queue_arbiter.sv
// Directed bench for op_queue_arbiter with a small behavioural deque as the queue.
`timescale 1ns/1ps
module tb_op_queue_arbiter;
  import op_queue_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IdW   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            cli_val;
  logic [N-1:0]            cli_rdy;
  logic [N-1:0][1:0]       cli_op;
  logic [N-1:0][W-1:0]     cli_data;
  logic                    rsp_val;
  logic [IdW-1:0]          rsp_id;
  logic [W-1:0]            rsp_data;
  logic                    rsp_err;
  logic enq_back_req, enq_front_req, deq_front_req, deq_back_req;
  logic enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl;
  logic [W-1:0]            enq_back_data, enq_front_data, deq_front_data, deq_back_data;

  always #5 clk = ~clk;

  op_queue_arbiter #(.p_nreqs(N), .p_depth(DEPTH), .p_bitwidth(W)) dut (
    .clk(clk), .rst(rst),
    .cli_val(cli_val), .cli_rdy(cli_rdy), .cli_op(cli_op), .cli_data(cli_data),
    .rsp_val(rsp_val), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .enq_back_req(enq_back_req), .enq_front_req(enq_front_req),
    .deq_front_req(deq_front_req), .deq_back_req(deq_back_req),
    .enq_back_cpl(enq_back_cpl), .enq_front_cpl(enq_front_cpl),
    .deq_front_cpl(deq_front_cpl), .deq_back_cpl(deq_back_cpl),
    .enq_back_data(enq_back_data), .enq_front_data(enq_front_data),
    .deq_front_data(deq_front_data), .deq_back_data(deq_back_data)
  );

  // Queue model: completes after lat cycles of req; noise pulses the non-matching cpl lines.
  logic [W-1:0] qmem [16];
  logic [3:0]   qhead;
  int           qcnt;
  int           wait_cnt;
  int           lat;
  logic         noise;
  logic [3:0]   reqv;
  logic         cpl_c;

  assign reqv           = {deq_back_req, deq_front_req, enq_front_req, enq_back_req};
  assign cpl_c          = (reqv != 4'd0) && (wait_cnt == lat);
  assign enq_back_cpl   = (cpl_c & enq_back_req)  | (noise & ~enq_back_req);
  assign enq_front_cpl  = (cpl_c & enq_front_req) | (noise & ~enq_front_req);
  assign deq_front_cpl  = (cpl_c & deq_front_req) | (noise & ~deq_front_req);
  assign deq_back_cpl   = (cpl_c & deq_back_req)  | (noise & ~deq_back_req);
  assign deq_front_data = qmem[qhead];
  assign deq_back_data  = qmem[4'(qhead + 4'(qcnt) - 4'd1)];

  always @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 0;
      qhead    <= 4'd0;
      qcnt     <= 0;
    end else if (cpl_c) begin
      wait_cnt <= 0;
      if (enq_back_req) begin
        qmem[4'(qhead + 4'(qcnt))] <= enq_back_data;
        qcnt <= qcnt + 1;
      end else if (enq_front_req) begin
        qmem[4'(qhead - 4'd1)] <= enq_front_data;
        qhead <= 4'(qhead - 4'd1);
        qcnt  <= qcnt + 1;
      end else if (deq_front_req) begin
        qhead <= 4'(qhead + 4'd1);
        qcnt  <= qcnt - 1;
      end else begin
        qcnt <= qcnt - 1;
      end
    end else if (reqv != 4'd0) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    cli_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One client transaction; returns response fields and cycle counts seen after accept.
  task automatic do_op(input int cli, input logic [1:0] op, input logic [W-1:0] data,
                       output logic [W-1:0] rd, output logic [IdW-1:0] rid, output logic rerr,
                       output int req_cycles, output int wait_cycles);
    int n;
    rd = '0; rid = '0; rerr = 1'b0; req_cycles = 0; wait_cycles = 0;
    @(negedge clk);
    cli_val[cli] = 1'b1; cli_op[cli] = op; cli_data[cli] = data;
    #1;
    n = 0;
    while (!cli_rdy[cli] && n < 50) begin @(negedge clk); #1; n++; end
    check("grant", 32'(cli_rdy), 32'(1 << cli));
    @(negedge clk);
    cli_val[cli] = 1'b0;
    n = 0;
    while (!rsp_val && n < 50) begin
      check("rdy_busy", 32'(cli_rdy), 32'd0);
      check("req_onehot", 32'($countones(reqv) <= 1), 32'd1);
      if (reqv != 4'd0) req_cycles++;
      @(negedge clk);
      n++;
    end
    check("rsp_seen", 32'(rsp_val), 32'd1);
    wait_cycles = n; rd = rsp_data; rid = rsp_id; rerr = rsp_err;
    check("req_low_at_rsp", 32'(reqv), 32'd0);
    @(negedge clk);
    check("rsp_pulse", 32'(rsp_val), 32'd0);
  endtask

  logic [W-1:0]   rd;
  logic [IdW-1:0] rid;
  logic           rerr;
  int             rc, wc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cli_val = '0; cli_op = '0; cli_data = '0; lat = 0; noise = 1'b0;
    do_reset();

    // Reset values
    check("rst_rdy", 32'(cli_rdy), 32'd0);
    check("rst_req", 32'(reqv), 32'd0);
    check("rst_rsp_val", 32'(rsp_val), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_enq_data", 32'(enq_back_data), 32'd0);

    // Client 2 ENQ_BACK 0x11, queue latency 3
    lat = 3;
    do_op(2, OP_ENQ_BACK, 8'h11, rd, rid, rerr, rc, wc);
    check("t1_req_cycles", 32'(rc), 32'd4);
    check("t1_id", 32'(rid), 32'd2);
    check("t1_data", 32'(rd), 32'd0);
    check("t1_err", 32'(rerr), 32'd0);
    check("t1_enq_data_idle", 32'(enq_back_data), 32'd0);

    // Round robin with all clients requesting enqs from reset
    do_reset();
    lat = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cli_op[i] = OP_ENQ_BACK; cli_data[i] = 8'(8'h20 + i);
    end
    cli_val = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      int n;
      n = 0;
      while (cli_rdy == '0 && n < 20) begin @(negedge clk); #1; n++; end
      check("rr_grant", 32'(cli_rdy), 32'(1 << (g % 4)));
      @(negedge clk);
      n = 0;
      while (!rsp_val && n < 20) begin
        check("rr_rdy_busy", 32'(cli_rdy), 32'd0);
        @(negedge clk);
        n++;
      end
      check("rr_rsp_id", 32'(rsp_id), 32'(g % 4));
      check("rr_rdy_resp", 32'(cli_rdy), 32'd0);
      if (g == 4) cli_val = '0;
      @(negedge clk);
      #1;
    end

    // Front/back enqueues then back/front dequeues from different clients
    do_reset();
    lat = 1;
    do_op(1, OP_ENQ_FRONT, 8'h0A, rd, rid, rerr, rc, wc);
    check("t3_enqf_id", 32'(rid), 32'd1);
    do_op(3, OP_ENQ_BACK, 8'h0B, rd, rid, rerr, rc, wc);
    check("t3_enqb_cycles", 32'(rc), 32'd2);
    lat = 2; noise = 1'b1;
    do_op(0, OP_DEQ_BACK, 8'hFF, rd, rid, rerr, rc, wc);
    noise = 1'b0;
    check("t3_deqb_data", 32'(rd), 32'h0B);
    check("t3_deqb_id", 32'(rid), 32'd0);
    check("t3_deqb_cycles", 32'(rc), 32'd3);
    lat = 0;
    do_op(2, OP_DEQ_FRONT, 8'hFF, rd, rid, rerr, rc, wc);
    check("t3_deqf_data", 32'(rd), 32'h0A);
    check("t3_deqf_id", 32'(rid), 32'd2);
    check("t3_deqf_cycles", 32'(rc), 32'd1);

`ifdef OPQ_ARB_OCC_EN
    // Occupancy refusal: deq on empty, enq on full
    do_reset();
    lat = 0;
    do_op(0, OP_DEQ_FRONT, 8'h00, rd, rid, rerr, rc, wc);
    check("occ_empty_err", 32'(rerr), 32'd1);
    check("occ_empty_wait", 32'(wc), 32'd0);
    check("occ_empty_req", 32'(rc), 32'd0);
    check("occ_empty_data", 32'(rd), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_op(i % 4, OP_ENQ_BACK, 8'(8'h40 + i), rd, rid, rerr, rc, wc);
      check("occ_fill_err", 32'(rerr), 32'd0);
    end
    do_op(1, OP_ENQ_BACK, 8'h77, rd, rid, rerr, rc, wc);
    check("occ_full_err", 32'(rerr), 32'd1);
    check("occ_full_req", 32'(rc), 32'd0);
    do_op(2, OP_DEQ_FRONT, 8'h00, rd, rid, rerr, rc, wc);
    check("occ_deq_err", 32'(rerr), 32'd0);
    check("occ_deq_data", 32'(rd), 32'h40);
`endif

    // Reset during ISSUE of a DEQ_BACK from client 1
    do_reset();
    lat = 0;
    do_op(0, OP_ENQ_BACK, 8'h55, rd, rid, rerr, rc, wc);
    lat = 6;
    @(negedge clk);
    cli_val[1] = 1'b1; cli_op[1] = OP_DEQ_BACK; cli_data[1] = '0;
    #1;
    check("rr_mid_grant", 32'(cli_rdy), 32'b0010);
    @(negedge clk);
    cli_val[1] = 1'b0;
    check("rr_mid_issue", 32'(deq_back_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rr_mid_req_drop", 32'(reqv), 32'd0);
    check("rr_mid_rsp_val", 32'(rsp_val), 32'd0);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (rsp_val) seen = 1'b1;
      end
      check("rr_mid_no_rsp", 32'(seen), 32'd0);
    end
    cli_val = 4'b1111;
    #1;
    check("rr_mid_next_grant", 32'(cli_rdy), 32'b0001);
    cli_val = '0;
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
